cmd_input_stage: RTL
====================

Name: cmd_input_stage

Overview:
- Front-end stage directly upstream of the ALU/display top level.
- Synchronises the switch-driven 12-bit command and the run pushbutton to clk, and debounces run.
- On each clean run press, captures one command word and presents it to the ALU over a valid/ready handshake.
- Guarantees exactly one ALU operation per physical press; presses arriving while a command is pending are dropped and flagged.

Parameters:
- CMD_W, 12, command word width; fields are op[11:9], addr1[8:6], addr2[5:3], addr3[2:0].
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a changed run level must persist before it is accepted (10 ms at 100 MHz); legal range ≥2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- command  in  CMD_W  raw slide-switch command, asynchronous to clk.
- run  in  1  raw run pushbutton, asynchronous, bouncy.
- cmd_out  out  CMD_W  captured command; stable while cmd_valid=1.
- cmd_valid  out  1  captured command pending for the ALU.
- cmd_ready  in  1  ALU accepts cmd_out this cycle.
- busy  out  1  equals cmd_valid; drives a status LED.
- press_dropped  out  1  one-cycle pulse when a debounced press is discarded.

Behaviour:
- Reset (rst_n=0, asynchronous): all flops clear. cmd_out=0, cmd_valid=0, busy=0, press_dropped=0, debounced level=0, counter=0, FSM=IDLE.
- Synchronisation: run and all command bits pass through 2-FF synchronisers. run_s and cmd_s are valid after 2 edges.
- Debounce:
  - Counter clears whenever run_s equals the debounced level.
  - Otherwise it increments each cycle.
  - When the mismatch has been seen for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - A mismatch shorter than DEBOUNCE_CYCLES is a glitch: no flip.
- press: combinational, asserted in the cycle the debounced level flips 0→1. Releases (1→0) generate nothing.
- Latency: run held clean high from edge 1 gives cmd_valid=1 after edge DEBOUNCE_CYCLES+3.
- FSM, 2 states:
  - IDLE: on press, cmd_out←cmd_s, cmd_valid←1, go to PEND.
  - PEND: cmd_out and cmd_valid hold. On cmd_ready=1 (handshake at that edge), cmd_valid←0 and go to IDLE.
  - PEND with press and no cmd_ready: press_dropped=1 for one cycle; cmd_out unchanged.
  - PEND with press and cmd_ready in the same cycle: handshake completes, the press is dropped with press_dropped=1, and the FSM returns to IDLE. No back-to-back capture.
  - cmd_ready while IDLE is ignored.
- Command bits changing while in PEND do not affect cmd_out.
- Button held through reset release: debounced level restarts at 0, so one press fires DEBOUNCE_CYCLES+3 edges after release.
- Reset mid-PEND: the pending command is lost and cmd_valid=0 immediately (asynchronous clear).

Decomposition:
- Package alu_cmd_pkg:
  - CMD_W.
  - Packed struct alu_cmd_t {op[2:0], addr1, addr2, addr3}.
  - Opcode enum: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b011, OP_CAS=3'b111.
  - FSM state enum {IDLE, PEND}.
- One sub-module, btn_debounce: input synchroniser + counter + debounced level + press output, parameterised by DEBOUNCE_CYCLES.
- Command synchroniser and FSM stay in cmd_input_stage.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: rst_n=0 with run=1 and command=12'hFFF → all outputs 0. Release rst_n, hold run → cmd_valid=1 after edge 7 with cmd_out=12'hFFF.
- Clean ADD press: command=12'b000_001_010_000, run high for 20 cycles, cmd_ready=0 → cmd_valid rises after edge 7 and holds, busy=1. Pulse cmd_ready for 1 cycle → cmd_valid=0 next cycle. No second valid while run stays high or on release.
- Bounce: run toggles 1,0,1,1,0,1,1,1,1,1 on successive cycles, then stays high → exactly one cmd_valid assertion. Pulses of 3 cycles or fewer never trigger.
- Drop while pending: capture SUB 12'b001_011_100_000 with cmd_ready=0. Release, then press again with command=12'b011_101_110_000 → press_dropped pulses once, cmd_out stays 12'h2E0.
- Simultaneous event: second press flip lands in the same cycle as cmd_ready=1 → handshake completes, press_dropped=1, FSM returns to IDLE, cmd_valid=0.
- Reset mid-PEND: CAS 12'b111_001_010_011 pending, rst_n pulsed low mid-cycle → cmd_valid and cmd_out clear asynchronously, before the next clk edge.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared types for the ALU command path: command word layout, opcodes and
// the front-end handshake FSM states.
package alu_cmd_pkg;

  localparam int CMD_W = 12;

  // op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] addr1;
    logic [2:0] addr2;
    logic [2:0] addr3;
  } alu_cmd_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b011,
    OP_CAS = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/cmd_input_stage_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, persistence counter and a
// debounced level. press is high for the one cycle in which the debounced
// level is newly 1; releases produce nothing. DEBOUNCE_CYCLES must be >= 2.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          btn_s;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  assign btn_s = sync_pipe[1];

  // Two-stage synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], btn};
  end

  // Count consecutive mismatch cycles; flip the level after DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (btn_s == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/cmd_input_stage.sv
// Front end ahead of the ALU: synchronises the switch command, debounces the
// run button and hands one captured command per press to the ALU over
// valid/ready. Presses arriving while a command is pending are dropped.
module cmd_input_stage
  import alu_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] command,
  input  logic             run,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             busy,
  output logic             press_dropped
);

  logic [CMD_W-1:0] cmd_m;
  logic [CMD_W-1:0] cmd_s;
  logic             press;
  alu_cmd_t         cmd_q;
  cmd_state_e       state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (run),
    .press (press)
  );

  // Two-stage synchroniser for the slide switches. The switches are static
  // by the time a press is accepted, so per-bit skew is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_m <= '0;
      cmd_s <= '0;
    end else begin
      cmd_m <= command;
      cmd_s <= cmd_m;
    end
  end

  // Capture on press, hold until the ALU takes it; flag presses that arrive
  // while pending, including the one that coincides with the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_q         <= '0;
      cmd_valid     <= 1'b0;
      press_dropped <= 1'b0;
    end else begin
      press_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            cmd_q     <= alu_cmd_t'(cmd_s);
            cmd_valid <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (press) press_dropped <= 1'b1;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_out = cmd_q;
  assign busy    = cmd_valid;

endmodule
